// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch PC, request/grant memory port with in-order
// responses, and a small prefetch FIFO that feeds the IF/ID register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] rom_inst_o,
    output logic        stallreq_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_br_target;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic          r_ds_pending;

    logic [CW:0]   w_sum;
    logic          w_credit;
    logic          w_issue;
    logic          w_rsp;
    logic          w_keep;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_br;
    logic [CW-1:0] w_out_after_rsp;
    logic          w_unused_stall;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_unused_stall = ^stall[5:2];

    // Credit uses start-of-cycle count; a pop in the same cycle frees nothing.
    assign w_sum    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit = (w_sum < (CW+1)'(DEPTH));

    assign imem_req_o  = rst & ~stall[0] & ~flush_i & ~branch_flag_i & w_credit;
    assign imem_addr_o = r_fetch_pc;
    assign w_issue     = imem_req_o & imem_gnt_i;

    // A pending delay slot is always kept, even ahead of queued discards.
    assign w_rsp           = imem_rvalid_i & (r_outstanding != '0);
    assign w_keep          = w_rsp & (r_ds_pending | (r_drop == '0));
    assign w_out_after_rsp = r_outstanding - CW'(w_rsp);

    assign w_empty = (r_count == '0);
    assign w_br    = branch_flag_i & ~flush_i;
    assign w_pop   = ~stall[1] & ~w_empty & ~flush_i;
    assign w_push  = w_keep & ~flush_i & ~(w_br & ~w_empty);

    assign if_pc_o    = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
    assign rom_inst_o = w_empty ? 32'h0 : r_fifo_inst[r_rd_ptr];
    assign stallreq_o = w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_br_target   <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_ds_pending  <= 1'b0;
        end else begin
            r_outstanding <= w_out_after_rsp + CW'(w_issue);
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (flush_i) begin
                r_count      <= '0;
                r_wr_ptr     <= r_rd_ptr;
                r_drop       <= w_out_after_rsp;
                r_ds_pending <= 1'b0;
                r_fetch_pc   <= new_pc_i;
                r_resp_pc    <= new_pc_i;
            end else if (w_br && !w_empty) begin
                // Head is the delay slot; everything younger is wrong-path.
                r_wr_ptr <= next_ptr(r_rd_ptr);
                if (w_pop) begin
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                    r_count  <= '0;
                end else begin
                    r_count  <= CW'(1);
                end
                r_drop       <= w_out_after_rsp;
                r_ds_pending <= 1'b0;
                r_fetch_pc   <= branch_target_i;
                r_resp_pc    <= branch_target_i;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= next_ptr(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_br) begin
                    r_fetch_pc <= branch_target_i;
                    if (w_keep) begin
                        r_resp_pc    <= branch_target_i;
                        r_drop       <= w_out_after_rsp;
                        r_ds_pending <= 1'b0;
                    end else begin
                        // Delay slot still in flight: keep it, discard the rest.
                        r_ds_pending <= 1'b1;
                        r_br_target  <= branch_target_i;
                        r_drop       <= (w_out_after_rsp == '0) ? '0 : w_out_after_rsp - CW'(1);
                    end
                end else if (w_keep) begin
                    if (r_ds_pending) begin
                        r_resp_pc    <= r_br_target;
                        r_ds_pending <= 1'b0;
                    end else begin
                        r_resp_pc <= r_resp_pc + 32'd4;
                    end
                end else if (w_rsp) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: 1-cycle memory model whose responses can be
// held back, and an expected-PC queue checked on every cycle the fetch stage
// hands a word to ID.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] rom_inst_o;
    logic        stallreq_o;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic        mem_hold;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_pc_o         (if_pc_o),
        .rom_inst_o      (rom_inst_o),
        .stallreq_o      (stallreq_o)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive memory response, observe a handoff to ID, advance memory.
    task automatic cyc();
        logic        g;
        logic        rv;
        logic [31:0] ga;
        logic [31:0] e;
        imem_rvalid_i = !mem_hold && (mem_q.size() > 0);
        imem_rdata_i  = (mem_q.size() > 0) ? word_at(mem_q[0]) : 32'h0;
        #1;
        g  = imem_req_o & imem_gnt_i;
        ga = imem_addr_o;
        rv = imem_rvalid_i;
        if (rst && !stall[1] && !flush_i && !stallreq_o) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", if_pc_o, e);
                check("pop_inst", rom_inst_o, word_at(e));
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            mem_q.delete();
        end else begin
            if (rv) mem_q.delete(0);
            if (g) mem_q.push_back(ga);
        end
        @(negedge clk);
    endtask

    task automatic run_drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < bound) begin
            cyc();
            k++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_i = '0;
        flush_i = 1'b0; new_pc_i = '0; imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; mem_hold = 1'b0;
        @(negedge clk);

        // Reset
        cyc(); #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd1);
        check("rst_pc", if_pc_o, 32'h0);
        cyc(); #1;
        check("rst_req2", 32'(imem_req_o), 32'd0);
        rst = 1'b1; #1;
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, 32'h0);

        // Streaming
        push_seq(32'h0, 8);
        run_drain(40);

        // Backpressure
        stall = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i >= 2) begin
                #1;
                check("bp_hold_pc", if_pc_o, 32'h20);
            end
        end
        #1;
        check("bp_req_off", 32'(imem_req_o), 32'd0);
        check("bp_inst", rom_inst_o, word_at(32'h20));
        stall = '0;
        push_seq(32'h20, 4);
        run_drain(30);

        // Flush and branch together
        flush_i = 1'b1; branch_flag_i = 1'b1; new_pc_i = 32'h180; branch_target_i = 32'h240;
        cyc();
        flush_i = 1'b0; branch_flag_i = 1'b0;
        push_seq(32'h180, 3);
        run_drain(20);

        // Branch with FIFO {0x10, 0x14}
        stall = 6'b000010; flush_i = 1'b1; new_pc_i = 32'h10;
        cyc();
        flush_i = 1'b0;
        repeat (5) cyc();
        #1;
        check("bf_head", if_pc_o, 32'h10);
        check("bf_req_off", 32'(imem_req_o), 32'd0);
        stall = '0; branch_flag_i = 1'b1; branch_target_i = 32'h100;
        exp_q.push_back(32'h10);
        cyc();
        branch_flag_i = 1'b0;
        push_seq(32'h100, 2);
        run_drain(20);

        // Branch with FIFO {0x30} and 0x34 still outstanding
        stall = 6'b000011; flush_i = 1'b1; new_pc_i = 32'h30;
        cyc();
        flush_i = 1'b0;
        repeat (2) cyc();
        mem_hold = 1'b1; stall = 6'b000010;
        repeat (2) cyc();
        #1;
        check("bo_req_off", 32'(imem_req_o), 32'd0);
        check("bo_stallreq", 32'(stallreq_o), 32'd1);
        mem_hold = 1'b0;
        cyc();
        mem_hold = 1'b1; #1;
        check("bo_head", if_pc_o, 32'h30);
        stall = '0; branch_flag_i = 1'b1; branch_target_i = 32'h300;
        exp_q.push_back(32'h30);
        cyc();
        branch_flag_i = 1'b0; mem_hold = 1'b0;
        push_seq(32'h300, 2);
        run_drain(20);

        // Branch with empty FIFO and two outstanding
        stall = 6'b000011; flush_i = 1'b1; new_pc_i = 32'h20;
        cyc();
        flush_i = 1'b0;
        repeat (2) cyc();
        mem_hold = 1'b1; stall = '0;
        repeat (2) cyc();
        #1;
        check("be_stallreq", 32'(stallreq_o), 32'd1);
        check("be_req_off", 32'(imem_req_o), 32'd0);
        branch_flag_i = 1'b1; branch_target_i = 32'h200;
        cyc();
        branch_flag_i = 1'b0; mem_hold = 1'b0;
        exp_q.push_back(32'h20);
        push_seq(32'h200, 2);
        run_drain(20);

        // Reset mid-stream
        rst = 1'b0;
        cyc(); cyc(); #1;
        check("mr_pc", if_pc_o, 32'h0);
        check("mr_stallreq", 32'(stallreq_o), 32'd1);
        check("mr_req", 32'(imem_req_o), 32'd0);
        rst = 1'b1; #1;
        check("mr_addr", imem_addr_o, 32'h0);
        push_seq(32'h0, 3);
        run_drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
